stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Command-level controller for the CPU operand stack macro. It accepts one stack command per handshake from decode (push, pop-N, dup, swap, over, replace) and breaks it into the macro's one-strobe-per-cycle push/pop primitives. It tracks depth, rejects underflow and overflow before any strobe issues, and tells the consumer when the macro's registered top outputs are current.

## Interface
- `W`, 35: stack word width.
- `AW`, 11: stack pointer width. Maximum depth is 2^AW−1 = 2047.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 3: opcode. PUSH=0, POP=1, DUP=2, SWAP=3, OVER=4, REPLACE=5, NOP=6, 7=illegal.
- `cmd_n` in AW: pop count for POP and REPLACE.
- `cmd_data` in W: value for PUSH and REPLACE.
- `done` out 1: one-cycle pulse when a command completes without error.
- `err` out 1: one-cycle pulse when a command is rejected.
- `err_code` out 2: 1=underflow, 2=overflow, 3=illegal op. Held until the next `done` or `err`.
- `depth` out AW: current element count.
- `tops_valid` out 1: `st__top_0` and `st__top_1` reflect the current depth.
- `st__push` / `st__pop` out 1: registered strobes to the macro. Never both high.
- `st__to_push` out W: registered push data.
- `st__to_pop` out AW: registered pop count.
- `st__top_0` / `st__top_1` in W: macro top-of-stack and next-of-stack.

## Operation
- States: IDLE, WAIT, POP, PUSH_A, PUSH_B.
- `cmd_ready` = (state==IDLE). All checks run at accept, using the current `depth`.
  - Underflow: POP/REPLACE with n>depth; DUP with depth<1; SWAP/OVER with depth<2.
  - Overflow: PUSH/DUP/OVER with depth==2047; REPLACE with n==0 and depth==2047.
  - A failed check pulses `err` next cycle. No strobe issues and state stays IDLE.
- Per-command behaviour:
  - PUSH: `st__push` with `cmd_data`; depth+1.
  - POP n: `st__pop` with n; depth−n. POP 0 and NOP give `done` only, no strobe.
  - REPLACE n: pop n (skipped if n==0), then push `cmd_data`; depth−n+1.
  - DUP / OVER: push captured `st__top_0` / `st__top_1`; depth+1.
  - SWAP: capture t0=`st__top_0`, t1=`st__top_1`; pop 2, push t0, push t1; depth unchanged.
- DUP, OVER and SWAP need `tops_valid`. If it is low at accept, go to WAIT and capture the tops on the first cycle it is high.
- Settle counter:
  - Reloads to 2 in every cycle a strobe register is high, otherwise decrements to 0.
  - `tops_valid` = (counter==0).
  - Covers the macro's one edge to move sp plus one edge to re-register the tops.
- `depth` updates on the same edge the strobe register is set.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1.
  - `depth`=0.
  - `done`, `err`, `st__push`, `st__pop` = 0.
  - `st__to_push`=0, `st__to_pop`=0, `err_code`=0.
  - Settle counter=2, so `tops_valid`=0 for 2 cycles.
- Single-strobe commands (PUSH, POP): accept at edge E0, strobe and `done` high in cycle E0→E1, state back in IDLE at E0. This sustains one push or pop per cycle back-to-back.
- Multi-strobe commands:
  - REPLACE (n>0): strobes in cycles E0→E1 and E1→E2; `done` with the last strobe.
  - SWAP with tops valid: strobes E0→E1, E1→E2, E2→E3.
  - DUP/OVER/SWAP immediately after any strobe: wait 2 cycles in WAIT first.
- Error response: 1 cycle after accept; `cmd_ready` stays high.
- `rst` asserted mid-sequence aborts any remaining strobes. The macro is not reset by this block; depth returns to 0 and the consumer must reset the macro alongside.

## Structure
- Shared package `cpu_stack_pkg` holds:
  - opcode localparams;
  - error-code localparams;
  - `STACK_W`=35, `STACK_AW`=11, `STACK_MAX`=2047.
- No sub-module: the settle counter and FSM live in one file.
- The bench instantiates this block with the real stack macro behind it.

## Test plan
- After reset: PUSH 0x1, PUSH 0x2, PUSH 0x3 on consecutive cycles → three `done` pulses, depth=3, `tops_valid` high 2 cycles after the last strobe, top_0=0x3, top_1=0x2.
- SWAP issued the cycle after the last PUSH → WAIT 2 cycles, then pop-2/push/push → top_0=0x2, top_1=0x3, depth=3.
- REPLACE n=2 data=0x7 on depth 3 → pop 2 then push 0x7 → depth=2, top_0=0x7, top_1=0x1.
- POP 5 at depth 2 → `err`, `err_code`=1, no strobe, depth=2. Opcode 7 → `err_code`=3.
- Fill to depth 2047, then PUSH → `err_code`=2, depth stays 2047. Then POP 2047 → depth=0, and DUP → underflow.
- Assert `rst` during the SWAP push phase → next cycle depth=0, no strobes, `cmd_ready`=1, `tops_valid`=0 for 2 cycles.

Source files
------------

// File: rtl/cpu_stack_pkg.sv
// Shared constants, opcodes and FSM state type for the operand stack
// command sequencer.
package cpu_stack_pkg;

  localparam int STACK_W   = 35;
  localparam int STACK_AW  = 11;
  localparam int STACK_MAX = 2047;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_OVER = 3'd4;
  localparam logic [2:0] OP_REPL = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_ILL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_PUSH_A,
    S_PUSH_B
  } state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Command handshake between decode (master) and the stack sequencer
// (slave): one command per valid/ready transfer.
interface stack_sequencer_if
  import cpu_stack_pkg::*;
#(
  parameter int W  = STACK_W,
  parameter int AW = STACK_AW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_n;
  logic [W-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_n, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_n, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/stack_sequencer.sv
// Breaks stack commands into one push/pop strobe per cycle for the
// operand stack macro, with depth tracking and a tops settle counter.
module stack_sequencer
  import cpu_stack_pkg::*;
#(
  parameter int W  = STACK_W,
  parameter int AW = STACK_AW
) (
  input  logic          clk,
  input  logic          rst,
  stack_sequencer_if.slave cmd,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] depth,
  output logic          tops_valid,
  output logic          st__push,
  output logic          st__pop,
  output logic [W-1:0]  st__to_push,
  output logic [AW-1:0] st__to_pop,
  input  logic [W-1:0]  st__top_0,
  input  logic [W-1:0]  st__top_1
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] depth_q, depth_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic [W-1:0]  to_push_q, to_push_d;
  logic [AW-1:0] to_pop_q, to_pop_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          done_q, done_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    cnt_q, cnt_d;

  logic is_push, is_pop, is_dup, is_swap;
  logic is_over, is_rep, illegal;
  logic n_zero, n_gt, at_max, lt2;
  logic under, over, fire;

  assign is_push = cmd.cmd_op == OP_PUSH;
  assign is_pop  = cmd.cmd_op == OP_POP;
  assign is_dup  = cmd.cmd_op == OP_DUP;
  assign is_swap = cmd.cmd_op == OP_SWAP;
  assign is_over = cmd.cmd_op == OP_OVER;
  assign is_rep  = cmd.cmd_op == OP_REPL;
  assign illegal = cmd.cmd_op == OP_ILL;

  assign n_zero = cmd.cmd_n == '0;
  assign n_gt   = cmd.cmd_n > depth_q;
  assign at_max = depth_q == AW'(STACK_MAX);
  assign lt2    = depth_q < AW'(2);

  assign cmd.cmd_ready = state_q == S_IDLE;
  assign tops_valid    = cnt_q == 2'd0;

  always_comb begin
    under = 1'b0;
    over  = 1'b0;
    unique case (1'b1)
      is_pop:  under = n_gt;
      is_rep: begin
        under = n_gt;
        over  = n_zero && at_max;
      end
      is_push: over = at_max;
      is_dup: begin
        under = depth_q == '0;
        over  = at_max;
      end
      is_over: begin
        under = lt2;
        over  = at_max;
      end
      is_swap: under = lt2;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    depth_d   = depth_q;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    to_push_d = to_push_q;
    to_pop_d  = to_pop_q;
    a_d       = a_q;
    b_d       = b_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    fire      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          if (illegal) begin
            err_d  = 1'b1;
            code_d = ERR_ILL;
          end else if (under) begin
            err_d  = 1'b1;
            code_d = ERR_UNDER;
          end else if (over) begin
            err_d  = 1'b1;
            code_d = ERR_OVER;
          end else begin
            unique case (1'b1)
              is_push: begin
                push_d    = 1'b1;
                to_push_d = cmd.cmd_data;
                depth_d   = depth_q + AW'(1);
                done_d    = 1'b1;
              end
              is_pop: begin
                if (!n_zero) begin
                  pop_d    = 1'b1;
                  to_pop_d = cmd.cmd_n;
                  depth_d  = depth_q - cmd.cmd_n;
                end
                done_d = 1'b1;
              end
              is_rep: begin
                if (n_zero) begin
                  push_d    = 1'b1;
                  to_push_d = cmd.cmd_data;
                  depth_d   = depth_q + AW'(1);
                  done_d    = 1'b1;
                end else begin
                  pop_d    = 1'b1;
                  to_pop_d = cmd.cmd_n;
                  depth_d  = depth_q - cmd.cmd_n;
                  b_d      = cmd.cmd_data;
                  state_d  = S_PUSH_B;
                end
              end
              is_dup, is_over, is_swap: begin
                op_d = cmd.cmd_op;
                if (tops_valid) fire = 1'b1;
                else state_d = S_WAIT;
              end
              default: done_d = 1'b1;
            endcase
          end
        end
      end
      S_WAIT: if (tops_valid) fire = 1'b1;
      S_POP: begin
        pop_d    = 1'b1;
        to_pop_d = AW'(2);
        depth_d  = depth_q - AW'(2);
        state_d  = S_PUSH_A;
      end
      S_PUSH_A: begin
        push_d    = 1'b1;
        to_push_d = a_q;
        depth_d   = depth_q + AW'(1);
        state_d   = S_PUSH_B;
      end
      S_PUSH_B: begin
        push_d    = 1'b1;
        to_push_d = b_q;
        depth_d   = depth_q + AW'(1);
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Tops are sampled on the edge they are known current.
    if (fire) begin
      unique case (op_d)
        OP_DUP, OP_OVER: begin
          push_d    = 1'b1;
          to_push_d = (op_d == OP_DUP) ? st__top_0 : st__top_1;
          depth_d   = depth_q + AW'(1);
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
        default: begin
          a_d = st__top_0;
          b_d = st__top_1;
          if (state_q == S_IDLE) begin
            pop_d    = 1'b1;
            to_pop_d = AW'(2);
            depth_d  = depth_q - AW'(2);
            state_d  = S_PUSH_A;
          end else begin
            state_d = S_POP;
          end
        end
      endcase
    end

    if (done_d) code_d = ERR_NONE;
  end

  always_comb begin
    if (push_d || pop_d) cnt_d = 2'd2;
    else if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    else cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      depth_q   <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      to_push_q <= '0;
      to_pop_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      cnt_q     <= 2'd2;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      depth_q   <= depth_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      to_push_q <= to_push_d;
      to_pop_q  <= to_pop_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign depth       = depth_q;
  assign st__push    = push_q;
  assign st__pop     = pop_q;
  assign st__to_push = to_push_q;
  assign st__to_pop  = to_pop_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer with a behavioural stack macro behind it;
// responses are scoreboarded against expectations queued at accept.
module tb_stack_sequencer;
  import cpu_stack_pkg::*;

  localparam int W  = STACK_W;
  localparam int AW = STACK_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_sequencer_if sif ();

  logic          done, err, tops_valid;
  logic [1:0]    err_code;
  logic [AW-1:0] depth;
  logic          st__push, st__pop;
  logic [W-1:0]  st__to_push;
  logic [AW-1:0] st__to_pop;
  logic [W-1:0]  st__top_0, st__top_1;

  stack_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (sif.slave),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .depth       (depth),
    .tops_valid  (tops_valid),
    .st__push    (st__push),
    .st__pop     (st__pop),
    .st__to_push (st__to_push),
    .st__to_pop  (st__to_pop),
    .st__top_0   (st__top_0),
    .st__top_1   (st__top_1)
  );

  // Stack macro: sp moves on the strobe edge, tops re-register next edge.
  logic [W-1:0]  mem [0:2047];
  logic [AW-1:0] sp;
  always @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      st__top_0 <= '0;
      st__top_1 <= '0;
    end else begin
      if (st__push) begin
        mem[sp] <= st__to_push;
        sp      <= sp + AW'(1);
      end else if (st__pop) begin
        sp <= sp - st__to_pop;
      end
      st__top_0 <= mem[sp - AW'(1)];
      st__top_1 <= mem[sp - AW'(2)];
    end
  end

  typedef struct {
    logic          is_err;
    logic [1:0]    code;
    logic [AW-1:0] dep;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] n;
    logic [W-1:0]  data;
    logic          is_err;
    logic [1:0]    code;
    logic [AW-1:0] dep;
    logic          chk;
    logic [W-1:0]  t0;
    logic [W-1:0]  t1;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [2:0] op, input int n,
                             input int d, input logic e,
                             input logic [1:0] c, input int dep,
                             input logic k, input int t0,
                             input int t1);
    vec_t r;
    r.op = op; r.n = AW'(n); r.data = W'(d);
    r.is_err = e; r.code = c; r.dep = AW'(dep);
    r.chk = k; r.t0 = W'(t0); r.t1 = W'(t1);
    return r;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("push_pop_excl", 64'(st__push & st__pop), 64'd0);
        if (done || err) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: done=%0b err=%0b", done, err);
          end else begin
            e = sb.pop_front();
            chk("resp_err", 64'(err), 64'(e.is_err));
            chk("resp_code", 64'(err_code), 64'(e.code));
            chk("resp_depth", 64'(depth), 64'(e.dep));
            if (err) chk("err_no_strobe", 64'(st__push | st__pop), 64'd0);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] n,
                       input logic [W-1:0] d, input logic e,
                       input logic [1:0] c, input logic [AW-1:0] dep);
    int k;
    exp_t x;
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = op;
    sif.cmd_n     = n;
    sif.cmd_data  = d;
    k = 0;
    while (!sif.cmd_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sif.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: ready=%0b want 1", sif.cmd_ready);
      sif.cmd_valid = 1'b0;
    end else begin
      x.is_err = e; x.code = c; x.dep = dep;
      sb.push_back(x);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    int k;
    sif.cmd_valid = 1'b0;
    k = 0;
    while ((sb.size() != 0 || !sif.cmd_ready) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0 || !sif.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic tops(input logic [W-1:0] t0, input logic [W-1:0] t1);
    int k;
    k = 0;
    while (!tops_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("tops_valid_wait", 64'(tops_valid), 64'd1);
    chk("top_0", 64'(st__top_0), 64'(t0));
    chk("top_1", 64'(st__top_1), 64'(t1));
  endtask

  initial begin
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = OP_NOP;
    sif.cmd_n     = '0;
    sif.cmd_data  = '0;
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(sif.cmd_ready), 64'd1);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_push", 64'(st__push), 64'd0);
    chk("rst_pop", 64'(st__pop), 64'd0);
    chk("rst_to_push", 64'(st__to_push), 64'd0);
    chk("rst_to_pop", 64'(st__to_pop), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_tv0", 64'(tops_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_tv1", 64'(tops_valid), 64'd0);
    @(posedge clk); #1;
    chk("rst_tv2", 64'(tops_valid), 64'd1);

    vt.push_back(v(OP_PUSH, 0, 1, 0, ERR_NONE, 1, 0, 0, 0));
    vt.push_back(v(OP_PUSH, 0, 2, 0, ERR_NONE, 2, 0, 0, 0));
    vt.push_back(v(OP_PUSH, 0, 3, 0, ERR_NONE, 3, 0, 0, 0));
    vt.push_back(v(OP_SWAP, 0, 0, 0, ERR_NONE, 3, 1, 2, 3));
    vt.push_back(v(OP_REPL, 2, 7, 0, ERR_NONE, 2, 1, 7, 1));
    vt.push_back(v(OP_POP, 5, 0, 1, ERR_UNDER, 2, 0, 0, 0));
    vt.push_back(v(OP_ILL, 0, 0, 1, ERR_ILL, 2, 0, 0, 0));
    vt.push_back(v(OP_NOP, 0, 0, 0, ERR_NONE, 2, 0, 0, 0));
    vt.push_back(v(OP_POP, 0, 0, 0, ERR_NONE, 2, 0, 0, 0));
    vt.push_back(v(OP_OVER, 0, 0, 0, ERR_NONE, 3, 1, 1, 7));
    vt.push_back(v(OP_DUP, 0, 0, 0, ERR_NONE, 4, 1, 1, 1));
    vt.push_back(v(OP_POP, 2, 0, 0, ERR_NONE, 2, 1, 7, 1));
    vt.push_back(v(OP_REPL, 0, 9, 0, ERR_NONE, 3, 1, 9, 7));
    vt.push_back(v(OP_POP, 1, 0, 0, ERR_NONE, 2, 1, 7, 1));

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].n, vt[i].data,
            vt[i].is_err, vt[i].code, vt[i].dep);
      if (vt[i].chk) begin
        idle();
        tops(vt[i].t0, vt[i].t1);
      end
    end
    idle();

    for (int i = 2; i < 2047; i++)
      issue(OP_PUSH, '0, W'(i + 100), 1'b0, ERR_NONE, AW'(i + 1));
    issue(OP_PUSH, '0, W'(5), 1'b1, ERR_OVER, AW'(2047));
    issue(OP_REPL, '0, W'(5), 1'b1, ERR_OVER, AW'(2047));
    idle();
    chk("full_depth", 64'(depth), 64'd2047);
    tops(W'(2146), W'(2145));
    issue(OP_POP, AW'(2047), '0, 1'b0, ERR_NONE, AW'(0));
    issue(OP_DUP, '0, '0, 1'b1, ERR_UNDER, AW'(0));
    issue(OP_SWAP, '0, '0, 1'b1, ERR_UNDER, AW'(0));
    idle();
    chk("empty_depth", 64'(depth), 64'd0);

    issue(OP_PUSH, '0, W'('h11), 1'b0, ERR_NONE, AW'(1));
    issue(OP_PUSH, '0, W'('h22), 1'b0, ERR_NONE, AW'(2));
    issue(OP_PUSH, '0, W'('h33), 1'b0, ERR_NONE, AW'(3));
    idle();
    tops(W'('h33), W'('h22));

    // SWAP aborted by reset during its push phase.
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = OP_SWAP;
    chk("swap_ready", 64'(sif.cmd_ready), 64'd1);
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
    chk("swap_pop", 64'(st__pop), 64'd1);
    chk("swap_pop_n", 64'(st__to_pop), 64'd2);
    @(posedge clk); #1;
    chk("swap_push_a", 64'(st__push), 64'd1);
    chk("swap_push_a_d", 64'(st__to_push), 64'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_depth", 64'(depth), 64'd0);
    chk("abort_push", 64'(st__push), 64'd0);
    chk("abort_pop", 64'(st__pop), 64'd0);
    chk("abort_ready", 64'(sif.cmd_ready), 64'd1);
    chk("abort_tv0", 64'(tops_valid), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    chk("abort_tv1", 64'(tops_valid), 64'd0);
    chk("abort_push1", 64'(st__push), 64'd0);
    @(posedge clk); #1;
    chk("abort_tv2", 64'(tops_valid), 64'd1);

    issue(OP_PUSH, '0, W'('h5), 1'b0, ERR_NONE, AW'(1));
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_top0", 64'(st__top_0), 64'h5);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
